// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared I/O map, register offsets and STATUS bit layout.
package data_mem_responder_pkg;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLES = 2'd2,
    REG_RSVD   = 2'd3
  } io_reg_e;
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 3;
endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// data_mem_responder_tx_fifo: transmit FIFO with push/pop arbitration and valid/ready drain.
module data_mem_responder_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          ready,
  output logic          push_ok,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;
  always_comb begin
    empty     = cnt_q == '0;
    full      = cnt_q == CW'(DEPTH);
    pop       = !empty && ready;
    push_ok   = push && (!full || pop);
    rd_d      = rd_q + AW'(pop);
    wr_d      = wr_q + AW'(push_ok);
    cnt_d     = cnt_q + CW'(push_ok) - CW'(pop);
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rd_q];
    count     = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-bus target with word RAM, TX FIFO, cycle counter and overflow flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_DBUS_WIDTH = 32,
  parameter int ADDR_DBUS_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH  = 10,
  parameter int FIFO_DEPTH      = 4,
  parameter int OUT_WIDTH       = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [ADDR_DBUS_WIDTH-1:0] i_MemAddr,
  input  logic [DATA_DBUS_WIDTH-1:0] i_MemWrData,
  input  logic                       i_MemWrEnable,
  output logic [DATA_DBUS_WIDTH-1:0] o_MemRdData,
  output logic [OUT_WIDTH-1:0]       o_OutData,
  output logic                       o_OutValid,
  input  logic                       i_OutReady
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_DBUS_WIDTH-1:0] ram_q [2**RAM_ADDR_WIDTH];
  logic [DATA_DBUS_WIDTH-1:0] cycles_q, cycles_d, status;
  logic [RAM_ADDR_WIDTH-1:0]  ram_idx;
  logic                       ovf_q, ovf_d, is_io, wr_io, push, push_ok, full, empty;
  logic [CW-1:0]              count;
  io_reg_e                    io_reg;
  logic                       unused_addr;
  assign unused_addr = ^{i_MemAddr[ADDR_DBUS_WIDTH-2:RAM_ADDR_WIDTH+2], i_MemAddr[1:0]};
  always_comb begin
    is_io    = i_MemAddr[ADDR_DBUS_WIDTH-1];
    ram_idx  = i_MemAddr[RAM_ADDR_WIDTH+1:2];
    io_reg   = io_reg_e'(i_MemAddr[3:2]);
    wr_io    = i_MemWrEnable && is_io;
    push     = wr_io && io_reg == REG_TXDATA;
    cycles_d = (wr_io && io_reg == REG_CYCLES) ? i_MemWrData : cycles_q + DATA_DBUS_WIDTH'(1);
    // a dropped push wins over a same-edge clear
    ovf_d    = (push && !push_ok) ||
               (ovf_q && !(wr_io && io_reg == REG_STATUS && i_MemWrData[ST_OVF]));
    status   = '0;
    status[ST_FULL]                  = full;
    status[ST_EMPTY]                 = empty;
    status[ST_OVF]                   = ovf_q;
    status[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(count);
    o_MemRdData = !is_io                ? ram_q[ram_idx] :
                  io_reg == REG_STATUS  ? status :
                  io_reg == REG_CYCLES  ? cycles_q : '0;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      cycles_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycles_q <= cycles_d;
      ovf_q    <= ovf_d;
    end
  always_ff @(posedge i_Clock)
    if (i_MemWrEnable && !is_io) ram_q[ram_idx] <= i_MemWrData;
  data_mem_responder_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(OUT_WIDTH)) u_tx_fifo (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .push      (push),
    .push_data (i_MemWrData[OUT_WIDTH-1:0]),
    .ready     (i_OutReady),
    .push_ok   (push_ok),
    .out_data  (o_OutData),
    .out_valid (o_OutValid),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors for RAM, TX FIFO, overflow, cycle counter and reset.
module tb_data_mem_responder;
  localparam logic [31:0] TX = 32'h8000_0000;
  localparam logic [31:0] ST = 32'h8000_0004;
  localparam logic [31:0] CY = 32'h8000_0008;
  localparam logic [31:0] RS = 32'h8000_000C;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        ready = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  data_mem_responder dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_MemAddr     (addr),
    .i_MemWrData   (wdata),
    .i_MemWrEnable (we),
    .o_MemRdData   (rdata),
    .o_OutData     (out_data),
    .o_OutValid    (out_valid),
    .i_OutReady    (ready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we = 1'b0;
    #1;
    d = rdata;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_vec++;
    if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL reset_status got %h want 00000002", v); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_ram();
    logic [31:0] v;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v);
    n_vec++;
    if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_read got %h want deadbeef", v); end
    rd(32'h0000_1010, v);
    n_vec++;
    if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_alias got %h want deadbeef", v); end
    wr(32'h0000_0017, 32'h1234_5678);
    rd(32'h0000_0014, v);
    n_vec++;
    if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_byteoff got %h want 12345678", v); end
    rd(32'h0000_0010, v);
    n_vec++;
    if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_neighbour got %h want deadbeef", v); end
  endtask
  task automatic test_io_misc();
    logic [31:0] v;
    wr(RS, 32'hFFFF_FFFF);
    rd(RS, v);
    n_vec++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL rsvd_read got %h want 0", v); end
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL rsvd_status got %h want 00000002", v); end
    rd(TX, v);
    n_vec++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL txdata_read got %h want 0", v); end
  endtask
  task automatic test_overflow_drain();
    logic [31:0] v;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(TX, 32'h0000_0041 + i);
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0401) begin n_bad++; $display("FAIL full_status got %h want 00000401", v); end
    wr(TX, 32'h0000_0045);
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0405) begin n_bad++; $display("FAIL ovf_status got %h want 00000405", v); end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_bad++; $display("FAIL held_head got %b/%h want 1/41", out_valid, out_data); end
    addr = 32'h0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + i)) begin
        n_bad++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, out_valid, out_data, 8'(8'h41 + i));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL drained got %b/%h want 0/00", out_valid, out_data); end
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0006) begin n_bad++; $display("FAIL drained_status got %h want 00000006", v); end
    ready = 1'b0;
  endtask
  task automatic test_ovf_clear();
    logic [31:0] v;
    wr(ST, 32'h0000_0003);
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0006) begin n_bad++; $display("FAIL ovf_noclear got %h want 00000006", v); end
    wr(ST, 32'hFFFF_FFFF);
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL ovf_clear got %h want 00000002", v); end
  endtask
  task automatic test_push_pop_full();
    logic [31:0] v;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(TX, 32'h0000_0051 + i);
    ready = 1'b1;
    wr(TX, 32'h0000_0055);
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0401) begin n_bad++; $display("FAIL pushpop_status got %h want 00000401", v); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h52 + i)) begin
        n_bad++; $display("FAIL pushpop_%0d got %b/%h want 1/%h", i, out_valid, out_data, 8'(8'h52 + i));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop_empty got %b want 0", out_valid); end
    ready = 1'b0;
  endtask
  task automatic test_cycles();
    logic [31:0] v;
    wr(CY, 32'hFFFF_FFFE);
    rd(CY, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL cycles_0 got %h want fffffffe", v); end
    tick();
    rd(CY, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cycles_1 got %h want ffffffff", v); end
    tick();
    rd(CY, v);
    n_vec++;
    if (v !== 32'h0000_0000) begin n_bad++; $display("FAIL cycles_wrap got %h want 00000000", v); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    ready = 1'b0;
    wr(32'h0000_0020, 32'hCAFE_F00D);
    wr(TX, 32'h0000_0061);
    wr(TX, 32'h0000_0062);
    addr = 32'h0;
    ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h62) begin n_bad++; $display("FAIL middrain got %b/%h want 1/62", out_valid, out_data); end
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL async_reset got %b/%h want 0/00", out_valid, out_data); end
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL reset_status2 got %h want 00000002", v); end
    rd(32'h0000_0020, v);
    n_vec++;
    if (v !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ram_keep got %h want cafef00d", v); end
    ready = 1'b0;
    wr(TX, 32'h0000_0077);
    rd(CY, v);
    n_vec++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL reset_cycles got %h want 0", v); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_write_ignored got %b want 0", out_valid); end
    tick();
    rd(ST, v);
    n_vec++;
    if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL post_reset_status got %h want 00000002", v); end
  endtask
  initial begin
    test_reset();
    test_ram();
    test_io_misc();
    test_overflow_drain();
    test_ovf_clear();
    test_push_pop_full();
    test_cycles();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Target side of the processor data-memory bus. It answers the core's combinational-read / clocked-write accesses with a word-addressed RAM and a small memory-mapped I/O window. The window holds a transmit FIFO drained by a valid/ready output stream and a free-running cycle counter. It sits between the single-cycle core's data port and the board-level output sink.

## Interface

Parameters:
- DATA_DBUS_WIDTH, 32, data bus width.
- ADDR_DBUS_WIDTH, 32, address bus width.
- RAM_ADDR_WIDTH, 10, log2 of the RAM depth in words (1024 words).
- FIFO_DEPTH, 4, transmit FIFO entries. Must be a power of two, ≥2.
- OUT_WIDTH, 8, output stream data width.

Ports:
- i_Clock, in, 1, single clock, rising edge.
- i_Reset, in, 1, asynchronous, active-high reset.
- i_MemAddr, in, ADDR_DBUS_WIDTH, byte address from the core.
- i_MemWrData, in, DATA_DBUS_WIDTH, write data.
- i_MemWrEnable, in, 1, write strobe for the current cycle.
- o_MemRdData, out, DATA_DBUS_WIDTH, read data, combinational from i_MemAddr.
- o_OutData, out, OUT_WIDTH, head of the transmit FIFO.
- o_OutValid, out, 1, FIFO not empty.
- i_OutReady, in, 1, sink accepts o_OutData this cycle.

## Operation

- Decode:
  - i_MemAddr[31] = 0 selects RAM. Word index = i_MemAddr[RAM_ADDR_WIDTH+1:2]. Upper bits and [1:0] are ignored, so the RAM aliases.
  - i_MemAddr[31] = 1 selects I/O. Register = i_MemAddr[3:2]. Other bits are ignored.
- RAM:
  - Read is combinational.
  - Write occurs at the clock edge when i_MemWrEnable = 1.
  - Contents are not reset.
- I/O registers:
  - 0x8000_0000 TXDATA. Write pushes i_MemWrData[OUT_WIDTH-1:0]. Read returns 0.
  - 0x8000_0004 STATUS. Read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[10:8] count (0..FIFO_DEPTH), all other bits 0. Writing 1 to bit2 clears overflow. All other written bits are ignored.
  - 0x8000_0008 CYCLES. Read returns the counter. Write loads the counter with i_MemWrData.
  - 0x8000_000C is reserved. Read returns 0. Write is ignored.
- FIFO:
  - Push is accepted when count < FIFO_DEPTH, or when a pop happens in the same cycle.
  - A push that is not accepted is dropped and sets overflow.
  - Pop occurs when o_OutValid && i_OutReady.
  - Simultaneous accepted push and pop leaves count unchanged.
- o_OutData equals the head entry when non-empty and 0 when empty.
- Cycle counter:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A CYCLES write takes priority over the increment on that edge.
- Overflow:
  - Set on a dropped push.
  - If a set and a clear occur on the same edge, set wins.

## Timing

- Reset (asynchronous) clears count, read/write pointers, overflow and counter.
  - Resulting outputs: o_OutValid = 0, o_OutData = 0.
  - o_MemRdData then reflects the addressed RAM word, or I/O value with empty = 1 and count 0.
  - Reset mid-stream discards all queued entries. Writes in the reset cycle have no effect on I/O state.
- Read latency is 0 cycles: o_MemRdData is valid in the same cycle as i_MemAddr, as the single-cycle core requires.
- Write latency: the effect is visible to reads in the cycle after the edge.
- FIFO is not fall-through. A push into an empty FIFO raises o_OutValid one cycle after the write edge.
- o_OutValid and o_OutData are stable until a pop. The sink may hold i_OutReady high continuously, giving 1 entry per cycle.
- A CYCLES read in cycle n returns the value v. The same read in cycle n+1 returns v+1.
- A STATUS read reflects state before the current cycle's write.

## Structure

- The shared types package holds:
  - IO_BASE = 32'h8000_0000.
  - Register offsets TXDATA/STATUS/CYCLES.
  - STATUS bit positions.
- Sub-module tx_fifo holds storage, pointers, count and push/pop arbitration.
- This top holds decode, RAM, counter, overflow flag and the read mux.

## Test plan

- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read alias 0x0000_1010 (RAM_ADDR_WIDTH 10) → 0xDEADBEEF.
- Hold i_OutReady = 0 and push 0x41, 0x42, 0x43, 0x44 to TXDATA → STATUS = 0x0000_0401. Push 0x45 → dropped, STATUS = 0x0000_0405. Then set ready=1 → outputs 0x41..0x44 on 4 consecutive cycles, then o_OutValid = 0 and STATUS = 0x0000_0006.
- FIFO full with i_OutReady = 1, push 0x55 in the same cycle → no overflow, count stays 4, and 0x55 appears last.
- Write CYCLES = 0xFFFF_FFFE, then read on the next 3 cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Push 2 entries, assert i_Reset mid-drain → immediately o_OutValid = 0, o_OutData = 0, and a STATUS read returns 0x0000_0002. A RAM word written before reset still reads back unchanged.
- Write STATUS with bit2 = 1 while overflow is set and no push occurs → overflow clears. With a simultaneous dropped push, overflow remains 1.
